// File: rtl/sd_spi_arbiter_if.sv
// Requester-side bus of the SD SPI arbiter: two read requesters sharing one host.
interface sd_spi_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [1:0]        r_block;
    logic [1:0]        r_multi_block;
    logic [1:0]        r_byte;
    logic [ADDR_W-1:0] block_addr_0;
    logic [ADDR_W-1:0] block_addr_1;
    logic [1:0]        req_busy;

    // Requesters drive commands and sample grant/busy.
    modport master (
        output req, r_block, r_multi_block, r_byte, block_addr_0, block_addr_1,
        input  gnt, req_busy
    );

    // The arbiter owns grant and per-port busy view.
    modport slave (
        input  req, r_block, r_multi_block, r_byte, block_addr_0, block_addr_1,
        output gnt, req_busy
    );
endinterface

// File: rtl/sd_spi_arbiter.sv
// Shares one sdspihost between the raw block reader (port 0) and the eluks
// engine (port 1): host reset/init sequencing, round-robin whole-transaction
// grants and a busy watchdog that re-initialises a hung host.
module sd_spi_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic              clk,
    input  logic              rst,
    sd_spi_arbiter_if.slave   bus,
    output logic              spi_rst,
    output logic              spi_r_block,
    output logic              spi_r_multi_block,
    output logic              spi_r_byte,
    output logic [ADDR_W-1:0] spi_block_addr,
    input  logic              spi_busy,
    input  logic              spi_err,
    output logic              init_done,
    output logic              init_err,
    output logic              timeout_err
);
    // One counter serves the reset pulse, the init settle window and the watchdog.
    localparam int MAX_CNT = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_SKIP = CNT_W'(2);

    typedef enum logic [2:0] {
        RESET_SPI,
        INIT_WAIT,
        IDLE,
        GRANT,
        RELEASE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             last_q, last_d;
    logic             spi_rst_q, spi_rst_d;
    logic             init_done_q, init_done_d;
    logic             init_err_q, init_err_d;
    logic             timeout_err_q, timeout_err_d;
    logic             wd_fire;

    // State and status registers; reset leaves the host in reset with port 0 favoured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RESET_SPI;
            cnt_q         <= '0;
            gnt_q         <= 2'b00;
            last_q        <= 1'b1;
            spi_rst_q     <= 1'b1;
            init_done_q   <= 1'b0;
            init_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gnt_q         <= gnt_d;
            last_q        <= last_d;
            spi_rst_q     <= spi_rst_d;
            init_done_q   <= init_done_d;
            init_err_q    <= init_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state: sequencing, arbitration and watchdog recovery.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        gnt_d         = gnt_q;
        last_d        = last_q;
        spi_rst_d     = spi_rst_q;
        init_done_d   = init_done_q;
        init_err_d    = init_err_q;
        timeout_err_d = timeout_err_q;
        wd_fire       = 1'b0;

        case (state_q)
            RESET_SPI: begin
                if (cnt_q == RST_LAST) begin
                    spi_rst_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = INIT_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            INIT_WAIT: begin
                // Host status is meaningless for the first two cycles after reset.
                if (cnt_q < INIT_SKIP) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (spi_err) begin
                    init_err_d = 1'b1;
                    spi_rst_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = RESET_SPI;
                end else if (!spi_busy) begin
                    init_done_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (bus.req == 2'b11) gnt_d = last_q ? 2'b01 : 2'b10;
                else                  gnt_d = bus.req;
                if (|bus.req) begin
                    last_d  = gnt_d[1];
                    state_d = GRANT;
                end
            end
            GRANT, RELEASE: begin
                if (spi_busy) begin
                    if (cnt_q == TO_LAST) wd_fire = 1'b1;
                    else                  cnt_d   = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                end
                if (wd_fire) begin
                    timeout_err_d = 1'b1;
                    gnt_d         = 2'b00;
                    spi_rst_d     = 1'b1;
                    init_done_d   = 1'b0;
                    cnt_d         = '0;
                    state_d       = RESET_SPI;
                end else if (state_q == GRANT) begin
                    // Only the owner dropping its request ends a grant.
                    if (!(|(bus.req & gnt_q))) begin
                        gnt_d   = 2'b00;
                        state_d = RELEASE;
                    end
                end else if (!spi_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = RESET_SPI;
        endcase
    end

    // Host commands follow the registered grant with zero latency.
    logic [1:0] own;
    assign own               = gnt_q & bus.req;
    assign spi_r_block       = |(bus.r_block & own);
    assign spi_r_multi_block = |(bus.r_multi_block & own);
    assign spi_r_byte        = |(bus.r_byte & own);
    assign spi_block_addr    = gnt_q[0] ? bus.block_addr_0 :
                               gnt_q[1] ? bus.block_addr_1 : '0;

    assign bus.gnt      = gnt_q;
    assign bus.req_busy = ~gnt_q | {2{spi_busy}};
    assign spi_rst      = spi_rst_q;
    assign init_done    = init_done_q;
    assign init_err     = init_err_q;
    assign timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Directed bench for sd_spi_arbiter: reset/init, grants, round robin,
// queuing, watchdog, init error and asynchronous reset.
module tb_sd_spi_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        spi_rst, spi_r_block, spi_r_multi_block, spi_r_byte;
    logic [31:0] spi_block_addr;
    logic        spi_busy, spi_err;
    logic        init_done, init_err, timeout_err;
    int          n_chk = 0;
    int          n_fail = 0;

    sd_spi_arbiter_if #(.ADDR_W(32)) bus ();

    sd_spi_arbiter #(.ADDR_W(32), .RST_CYCLES(16), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .spi_rst(spi_rst), .spi_r_block(spi_r_block),
        .spi_r_multi_block(spi_r_multi_block), .spi_r_byte(spi_r_byte),
        .spi_block_addr(spi_block_addr), .spi_busy(spi_busy), .spi_err(spi_err),
        .init_done(init_done), .init_err(init_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b0; spi_busy = 1'b1; spi_err = 1'b0;
        bus.req = 2'b00; bus.r_block = 2'b00; bus.r_multi_block = 2'b00; bus.r_byte = 2'b00;
        bus.block_addr_0 = '0; bus.block_addr_1 = '0;
        tick(2);
        n_chk++; if (spi_rst !== 1'b1) begin n_fail++; $display("FAIL rst_spi_rst got %b want 1", spi_rst); end
        n_chk++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL rst_gnt got %b want 00", bus.gnt); end
        n_chk++; if (bus.req_busy !== 2'b11) begin n_fail++; $display("FAIL rst_req_busy got %b want 11", bus.req_busy); end
        n_chk++; if ({init_done, init_err, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL rst_status got %b want 000", {init_done, init_err, timeout_err}); end
        rst = 1'b1;
        n = 0;
        while (spi_rst === 1'b1 && n < 100) begin tick(); n++; end
        n_chk++; if (n !== 16) begin n_fail++; $display("FAIL spi_rst_len got %0d want 16", n); end
        tick(24);
        n_chk++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL init_early got %b want 0", init_done); end
        spi_busy = 1'b0;
        tick();
        n_chk++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done got %b want 1", init_done); end
        n_chk++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL init_gnt got %b want 00", bus.gnt); end
    endtask

    task automatic test_round_robin();
        bus.req = 2'b11;
        tick();
        n_chk++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL rr_first got %b want 01", bus.gnt); end
        bus.req = 2'b10;
        tick();
        n_chk++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL rr_gap got %b want 00", bus.gnt); end
        tick(2);
        n_chk++; if (bus.gnt !== 2'b10) begin n_fail++; $display("FAIL rr_second got %b want 10", bus.gnt); end
        bus.req = 2'b00;
        tick(2);
        bus.req = 2'b11;
        tick();
        n_chk++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL rr_third got %b want 01", bus.gnt); end
        bus.req = 2'b00;
        tick(2);
    endtask

    task automatic test_single();
        bus.req = 2'b01; bus.block_addr_0 = 32'd19;
        tick();
        n_chk++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt got %b want 01", bus.gnt); end
        bus.r_block = 2'b01; bus.r_multi_block = 2'b01; bus.r_byte = 2'b01;
        #1;
        n_chk++; if ({spi_r_block, spi_r_multi_block, spi_r_byte} !== 3'b111) begin n_fail++; $display("FAIL single_cmd got %b want 111", {spi_r_block, spi_r_multi_block, spi_r_byte}); end
        n_chk++; if (spi_block_addr !== 32'd19) begin n_fail++; $display("FAIL single_addr got %0d want 19", spi_block_addr); end
        n_chk++; if (bus.req_busy !== 2'b10) begin n_fail++; $display("FAIL single_busy got %b want 10", bus.req_busy); end
        bus.r_block = 2'b00; bus.r_multi_block = 2'b00; bus.r_byte = 2'b00; spi_busy = 1'b1;
        tick();
        n_chk++; if ({spi_r_block, bus.req_busy} !== 3'b011) begin n_fail++; $display("FAIL single_busy2 got %b want 011", {spi_r_block, bus.req_busy}); end
        bus.req = 2'b00;
        tick();
        n_chk++; if (bus.gnt !== 2'b00 || spi_block_addr !== 32'd0) begin n_fail++; $display("FAIL single_release got %b/%0d want 00/0", bus.gnt, spi_block_addr); end
        tick();
        spi_busy = 1'b0;
        tick();
    endtask

    task automatic test_queue();
        bus.req = 2'b01; bus.block_addr_1 = 32'hABCD;
        tick();
        n_chk++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL queue_gnt got %b want 01", bus.gnt); end
        bus.req = 2'b11; bus.r_block = 2'b10;
        #1;
        n_chk++; if (spi_r_block !== 1'b0) begin n_fail++; $display("FAIL queue_mask got %b want 0", spi_r_block); end
        n_chk++; if (bus.req_busy !== 2'b10) begin n_fail++; $display("FAIL queue_busy got %b want 10", bus.req_busy); end
        tick(3);
        n_chk++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL queue_hold got %b want 01", bus.gnt); end
        bus.req = 2'b10; bus.r_block = 2'b00;
        tick(3);
        n_chk++; if (bus.gnt !== 2'b10) begin n_fail++; $display("FAIL queue_next got %b want 10", bus.gnt); end
        n_chk++; if (spi_block_addr !== 32'hABCD) begin n_fail++; $display("FAIL queue_addr got %h want abcd", spi_block_addr); end
        bus.req = 2'b00;
        tick(2);
    endtask

    task automatic test_timeout();
        bus.req = 2'b01;
        tick();
        spi_busy = 1'b1;
        tick(63);
        n_chk++; if (timeout_err !== 1'b0 || bus.gnt !== 2'b01) begin n_fail++; $display("FAIL wd_early got %b/%b want 0/01", timeout_err, bus.gnt); end
        tick();
        n_chk++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL wd_err got %b want 1", timeout_err); end
        n_chk++; if ({bus.gnt, spi_rst, init_done} !== 4'b0010) begin n_fail++; $display("FAIL wd_recover got %b want 0010", {bus.gnt, spi_rst, init_done}); end
        bus.req = 2'b00; spi_busy = 1'b0;
    endtask

    task automatic test_init_err();
        int n;
        n = 0;
        while (spi_rst === 1'b1 && n < 100) begin tick(); n++; end
        n_chk++; if (n !== 16) begin n_fail++; $display("FAIL ie_rst_len got %0d want 16", n); end
        spi_err = 1'b1;
        tick(2);
        n_chk++; if (init_err !== 1'b0) begin n_fail++; $display("FAIL ie_early got %b want 0", init_err); end
        tick();
        n_chk++; if ({init_err, spi_rst, timeout_err} !== 3'b111) begin n_fail++; $display("FAIL ie_set got %b want 111", {init_err, spi_rst, timeout_err}); end
        spi_err = 1'b0;
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin tick(); n++; end
        n_chk++; if (n !== 19) begin n_fail++; $display("FAIL ie_reinit got %0d want 19", n); end
    endtask

    task automatic test_async_reset();
        bus.req = 2'b01;
        tick();
        n_chk++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL ar_gnt got %b want 01", bus.gnt); end
        #2 rst = 1'b0;
        #1;
        n_chk++; if ({bus.gnt, bus.req_busy, spi_rst} !== 5'b00111) begin n_fail++; $display("FAIL ar_out got %b want 00111", {bus.gnt, bus.req_busy, spi_rst}); end
        n_chk++; if ({init_done, init_err, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL ar_status got %b want 000", {init_done, init_err, timeout_err}); end
        bus.req = 2'b00;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_queue();
        test_timeout();
        test_init_err();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
